// File: rtl/instruction_pkg.sv
// Shared types and constants for the instruction-fetch path.
package instruction_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP        = 32'h0000_0013;
    localparam logic [31:0] IMEM_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & IMEM_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} pairs; head is readable combinationally.
module fetch_buffer
    import instruction_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Flush wins over push so a squashed response never lands in the buffer.
    assign do_push   = push && !flush;
    assign do_pop    = pop && !flush;
    assign head_data = mem[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(do_push && !do_pop && count_reg == CNT_W'(BUF_DEPTH)));

endmodule

// File: rtl/fetch_control.sv
// Fetch sequencer: owns the fetch PC, issues credit-limited memory requests,
// buffers responses and hands them to execution, squashing on redirect.
module fetch_control
    import instruction_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter int          CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_v_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    fetch_state_e     state_reg, state_next;
    logic [31:0]      fetch_pc_reg, resp_pc_reg;
    logic [31:0]      last_pc_reg, last_inst_reg;
    logic [CNT_W-1:0] outstanding_reg, kill_cnt_reg, occupancy;
    logic [CNT_W:0]   credit_used;
    logic             fire, push, pop, buf_empty;
    fetch_entry_t     head, push_entry;

    // Credit covers both in-flight requests and buffered entries, so the
    // buffer can never overflow regardless of memory latency.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, occupancy};
    assign imem_req_o  = (state_reg != BOOT) && !redirect_i
                         && (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr_o = fetch_pc_reg;
    assign fire        = imem_req_o && imem_gnt_i;

    assign push       = imem_rvalid_i && (kill_cnt_reg == '0) && !redirect_i;
    assign push_entry = {resp_pc_reg, imem_rdata_i};

    assign pop      = !buf_empty && (state_reg == RUN) && !redirect_i;
    assign inst_v_o = pop;
    assign inst_o   = pop ? head.inst : last_inst_reg;
    assign pc_o     = pop ? head.pc   : last_pc_reg;

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_i),
        .push_data (push_entry),
        .head_data (head),
        .empty     (buf_empty),
        .count     (occupancy)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     if (halt_i && !redirect_i) state_next = HALTED;
            HALTED:  if (!halt_i && !redirect_i) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            kill_cnt_reg    <= '0;
            last_pc_reg     <= '0;
            last_inst_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_reg + CNT_W'(fire) - CNT_W'(imem_rvalid_i);
            if (redirect_i) begin
                fetch_pc_reg <= align_pc(redirect_pc_i);
                resp_pc_reg  <= align_pc(redirect_pc_i);
                // Every request still in flight after this cycle is wrong-path.
                kill_cnt_reg <= outstanding_reg - CNT_W'(imem_rvalid_i);
            end else begin
                if (fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
                if (push) resp_pc_reg  <= resp_pc_reg + 32'd4;
                if (imem_rvalid_i && kill_cnt_reg != '0)
                    kill_cnt_reg <= kill_cnt_reg - CNT_W'(1);
            end
            if (pop) begin
                last_pc_reg   <= head.pc;
                last_inst_reg <= head.inst;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        kill_cnt_reg <= outstanding_reg);

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with an in-order memory model returning addr as data.
module tb_fetch_control;
    import instruction_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        inst_v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    fetch_control dut (
        .clk           (clk),
        .reset         (reset),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_v_o      (inst_v_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0, n_fail = 0;
    int          cyc = 0, lat = 1, bench_out = 0, issued = 0;
    bit          gnt_toggle = 1'b0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc = 32'd0;
    logic        s_req, s_v;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, score issues, advance memory model.
    task automatic cycle();
        @(negedge clk);
        s_req = imem_req_o; s_addr = imem_addr_o;
        s_v = inst_v_o; s_pc = pc_o; s_inst = inst_o;
        if (s_v) begin
            $display("cycle %0d issue pc=%h inst=%h", cyc, s_pc, s_inst);
            chk("issue_pc", s_pc, exp_pc);
            chk("issue_inst", s_inst, exp_pc);
            exp_pc = exp_pc + 32'd4;
            issued++;
        end
        if (imem_rvalid_i) bench_out--;
        if (s_req && imem_gnt_i) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat);
            bench_out++;
            chk("credit", 32'(bench_out <= 2), 32'd1);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_gnt_i = gnt_toggle ? ~imem_gnt_i : 1'b1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mq_addr.pop_front();
            void'(mq_due.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hdead_beef;
        end
    endtask

    task automatic wait_issue(input string tag);
        int iss;
        iss = issued;
        for (int i = 0; i < 30 && issued == iss; i++) cycle();
        chk(tag, 32'(issued - iss), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic [31:0] aligned, input logic hold);
        redirect_i = 1'b1; redirect_pc_i = target; halt_i = hold;
        cycle();
        chk("redir_inst_v", 32'(s_v), 32'd0);
        chk("redir_req", 32'(s_req), 32'd0);
        redirect_i = 1'b0;
        exp_pc = aligned;
        for (int i = 0; i < 10 && !s_req; i++) cycle();
        for (int i = 0; i < 10 && !(s_req && !imem_gnt_i) && !s_req; i++) cycle();
        if (!hold) chk("redir_addr", s_addr, aligned);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_inst_v", 32'(inst_v_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);

        // Boot and first fetches at latency 1, gnt always high.
        reset = 1'b0; cyc = 0;
        cycle(); chk("boot_req", 32'(s_req), 32'd0);
        cycle(); chk("first_req", 32'(s_req), 32'd1); chk("first_addr", s_addr, 32'h0);
        cycle(); chk("c2_inst_v", 32'(s_v), 32'd0); chk("c2_addr", s_addr, 32'h4);
        cycle(); chk("c3_inst_v", 32'(s_v), 32'd1); chk("c3_req", 32'(s_req), 32'd0);
        cycle(); chk("c4_inst_v", 32'(s_v), 32'd1); chk("c4_addr", s_addr, 32'h8);
        repeat (8) cycle();

        // Toggling grant with latency 2.
        gnt_toggle = 1'b1; lat = 2;
        begin
            int iss0;
            iss0 = issued;
            repeat (30) cycle();
            chk("toggle_progress", 32'(issued - iss0 > 4), 32'd1);
        end

        // Redirect with two requests in flight (latency 3).
        gnt_toggle = 1'b0; lat = 3;
        for (int i = 0; i < 20 && bench_out != 2; i++) cycle();
        chk("redir_setup_out", 32'(bench_out), 32'd2);
        do_redirect(32'h100, 32'h100, 1'b0);
        wait_issue("redir_issue_100");
        repeat (6) cycle();

        // Misaligned target is word-aligned.
        lat = 1;
        repeat (4) cycle();
        do_redirect(32'h302, 32'h300, 1'b0);
        wait_issue("redir_issue_300");
        repeat (6) cycle();

        // Halt in a steady stream: buffer fills to two entries, then requests stop.
        halt_i = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("halt_inst_v", 32'(s_v), 32'd0);
        end
        chk("halt_req", 32'(s_req), 32'd0);
        halt_i = 1'b0;
        cycle(); chk("release_inst_v0", 32'(s_v), 32'd0);
        cycle(); chk("release_inst_v1", 32'(s_v), 32'd1);
        cycle(); chk("release_inst_v2", 32'(s_v), 32'd1);
        repeat (4) cycle();

        // Halt and redirect together: redirect applies, issue stays frozen.
        do_redirect(32'h200, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("hr_inst_v", 32'(s_v), 32'd0);
        end
        halt_i = 1'b0;
        wait_issue("hr_issue_200");
        repeat (4) cycle();

        // Asynchronous reset with one request outstanding.
        lat = 2;
        for (int i = 0; i < 20 && bench_out != 1; i++) cycle();
        chk("rst_setup_out", 32'(bench_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req_o), 32'd0);
        chk("arst_inst_v", 32'(inst_v_o), 32'd0);
        chk("arst_pc", pc_o, 32'd0);
        chk("arst_inst", inst_o, 32'd0);
        mq_addr.delete(); mq_due.delete();
        bench_out = 0; imem_rvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; cyc = 0; exp_pc = 32'h0;
        cycle(); chk("reboot_req", 32'(s_req), 32'd0);
        cycle(); chk("reboot_addr", s_addr, 32'h0);
        wait_issue("reboot_issue_0");
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

endmodule
